exec_ctrl_unit: RTL and testbench

EXEC_CTRL_UNIT -- requirements
Module: exec_ctrl_unit

---
 rtl/exec_ctrl_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_exec_ctrl_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl_unit.sv
// RV32I main decoder and ALU, fully combinational, plus registered result/zero/sticky-illegal status.
// Shift instructions are decoded only when EXU_SHIFT_EN is defined; otherwise they decode as illegal.
module exec_ctrl_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  op,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_write,
  output logic [5:0]  ext_op,
  output logic [4:0]  alu_op,
  output logic [2:0]  npc_op,
  output logic        alu_src,
  output logic [2:0]  dm_type,
  output logic [1:0]  wd_sel,
  output logic [31:0] alu_b,
  output logic [31:0] alu_c,
  output logic        zero,
  output logic        illegal,
  output logic [31:0] c_q,
  output logic        zero_q,
  output logic        illegal_seen
);

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,  ALU_LUI  = 5'd1,  ALU_AUIPC = 5'd2,  ALU_ADD  = 5'd3,
    ALU_SUB   = 5'd4,  ALU_BNE  = 5'd5,  ALU_BLT   = 5'd6,  ALU_BGE  = 5'd7,
    ALU_BLTU  = 5'd8,  ALU_BGEU = 5'd9,  ALU_SLT   = 5'd10, ALU_SLTU = 5'd11,
    ALU_XOR   = 5'd12, ALU_OR   = 5'd13, ALU_AND   = 5'd14, ALU_SLL  = 5'd15,
    ALU_SRL   = 5'd16, ALU_SRA  = 5'd17
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] EXT_NONE  = 6'b000000;
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  alu_op_e     aop;
  logic        dec_ok, is_br, is_jal, is_jalr;
  logic        rw, mw, src;
  logic [5:0]  ext;
  logic [2:0]  dm;
  logic [1:0]  wd;
  logic        f7_0, f7_20;
  logic [31:0] opa;
  logic [31:0] c_d;
  logic        zero_d, illegal_seen_d;

  assign f7_0  = (funct7 == 7'b0000000);
  assign f7_20 = (funct7 == 7'b0100000);

  always_comb begin
    dec_ok  = 1'b1;
    aop     = ALU_NOP;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    rw      = 1'b0;
    mw      = 1'b0;
    src     = 1'b0;
    ext     = EXT_NONE;
    dm      = DM_W;
    wd      = WD_ALU;
    case (op)
      OP_R: begin
        rw = 1'b1;
        case (funct3)
          3'b000: begin
            if (f7_0) aop = ALU_ADD;
            else if (f7_20) aop = ALU_SUB;
            else dec_ok = 1'b0;
          end
`ifdef EXU_SHIFT_EN
          3'b001: begin aop = ALU_SLL; dec_ok = f7_0; end
          3'b101: begin
            if (f7_0) aop = ALU_SRL;
            else if (f7_20) aop = ALU_SRA;
            else dec_ok = 1'b0;
          end
`endif
          3'b010: begin aop = ALU_SLT;  dec_ok = f7_0; end
          3'b011: begin aop = ALU_SLTU; dec_ok = f7_0; end
          3'b100: begin aop = ALU_XOR;  dec_ok = f7_0; end
          3'b110: begin aop = ALU_OR;   dec_ok = f7_0; end
          3'b111: begin aop = ALU_AND;  dec_ok = f7_0; end
          default: dec_ok = 1'b0;
        endcase
      end
      OP_IALU: begin
        rw  = 1'b1;
        src = 1'b1;
        ext = EXT_I;
        case (funct3)
          3'b000: aop = ALU_ADD;
          3'b010: aop = ALU_SLT;
          3'b011: aop = ALU_SLTU;
          3'b100: aop = ALU_XOR;
          3'b110: aop = ALU_OR;
          3'b111: aop = ALU_AND;
`ifdef EXU_SHIFT_EN
          3'b001: begin ext = EXT_SHAMT; aop = ALU_SLL; dec_ok = f7_0; end
          3'b101: begin
            ext = EXT_SHAMT;
            if (f7_0) aop = ALU_SRL;
            else if (f7_20) aop = ALU_SRA;
            else dec_ok = 1'b0;
          end
`endif
          default: dec_ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        rw  = 1'b1;
        src = 1'b1;
        ext = EXT_I;
        aop = ALU_ADD;
        wd  = WD_MEM;
        case (funct3)
          3'b000:  dm = DM_B;
          3'b001:  dm = DM_H;
          3'b010:  dm = DM_W;
          3'b100:  dm = DM_BU;
          3'b101:  dm = DM_HU;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        mw  = 1'b1;
        src = 1'b1;
        ext = EXT_S;
        aop = ALU_ADD;
        case (funct3)
          3'b000:  dm = DM_B;
          3'b001:  dm = DM_H;
          3'b010:  dm = DM_W;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        is_br = 1'b1;
        ext   = EXT_B;
        case (funct3)
          3'b000:  aop = ALU_SUB;
          3'b001:  aop = ALU_BNE;
          3'b100:  aop = ALU_BLT;
          3'b101:  aop = ALU_BGE;
          3'b110:  aop = ALU_BLTU;
          3'b111:  aop = ALU_BGEU;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        rw     = 1'b1;
        wd     = WD_PC;
        ext    = EXT_J;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        rw      = 1'b1;
        wd      = WD_PC;
        src     = 1'b1;
        ext     = EXT_I;
        aop     = ALU_ADD;
        is_jalr = 1'b1;
        dec_ok  = (funct3 == 3'b000);
      end
      OP_LUI:   begin rw = 1'b1; src = 1'b1; ext = EXT_U; aop = ALU_LUI;   end
      OP_AUIPC: begin rw = 1'b1; src = 1'b1; ext = EXT_U; aop = ALU_AUIPC; end
      default: dec_ok = 1'b0;
    endcase
    // An undecoded combination must not leak any partially-set control.
    if (!dec_ok) begin
      aop     = ALU_NOP;
      is_br   = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      rw      = 1'b0;
      mw      = 1'b0;
      src     = 1'b0;
      ext     = EXT_NONE;
      dm      = DM_W;
      wd      = WD_ALU;
    end
  end

  assign opa   = (aop == ALU_AUIPC) ? pc : rd1;
  assign alu_b = src ? imm : rd2;

  // Branch ops yield zero exactly when the branch is taken.
  always_comb begin
    case (aop)
      ALU_LUI:            alu_c = alu_b;
      ALU_AUIPC, ALU_ADD: alu_c = opa + alu_b;
      ALU_SUB:            alu_c = opa - alu_b;
      ALU_BNE:            alu_c = {31'd0, (opa == alu_b)};
      ALU_BLT:            alu_c = {31'd0, ($signed(opa) >= $signed(alu_b))};
      ALU_BGE:            alu_c = {31'd0, ($signed(opa) < $signed(alu_b))};
      ALU_BLTU:           alu_c = {31'd0, (opa >= alu_b)};
      ALU_BGEU:           alu_c = {31'd0, (opa < alu_b)};
      ALU_SLT:            alu_c = {31'd0, ($signed(opa) < $signed(alu_b))};
      ALU_SLTU:           alu_c = {31'd0, (opa < alu_b)};
      ALU_XOR:            alu_c = opa ^ alu_b;
      ALU_OR:             alu_c = opa | alu_b;
      ALU_AND:            alu_c = opa & alu_b;
`ifdef EXU_SHIFT_EN
      ALU_SLL:            alu_c = opa << alu_b[4:0];
      ALU_SRL:            alu_c = opa >> alu_b[4:0];
      ALU_SRA:            alu_c = $unsigned($signed(opa) >>> alu_b[4:0]);
`endif
      default:            alu_c = 32'd0;
    endcase
  end

  assign zero      = (alu_c == 32'd0);
  assign illegal   = ~dec_ok;
  assign reg_write = rw;
  assign mem_write = mw;
  assign ext_op    = ext;
  assign alu_op    = aop;
  assign alu_src   = src;
  assign dm_type   = dm;
  assign wd_sel    = wd;
  assign npc_op    = {is_jalr, is_jal, is_br & zero};

  assign c_d            = alu_c;
  assign zero_d         = zero;
  assign illegal_seen_d = illegal_seen | illegal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_q          <= 32'd0;
      zero_q       <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      c_q          <= c_d;
      zero_q       <= zero_d;
      illegal_seen <= illegal_seen_d;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Bench for exec_ctrl_unit: instruction-level reference model checked every cycle,
// plus hand-computed literal expectations for key instructions, status registers and reset.
module tb_exec_ctrl_unit;

  logic        clk, rstn;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [31:0] pc, rd1, rd2, imm;
  logic        reg_write, mem_write;
  logic [5:0]  ext_op;
  logic [4:0]  alu_op;
  logic [2:0]  npc_op;
  logic        alu_src;
  logic [2:0]  dm_type;
  logic [1:0]  wd_sel;
  logic [31:0] alu_b, alu_c;
  logic        zero, illegal;
  logic [31:0] c_q;
  logic        zero_q, illegal_seen;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

`ifdef EXU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  exec_ctrl_unit dut (
    .clk(clk), .rstn(rstn), .op(op), .funct7(funct7), .funct3(funct3), .pc(pc),
    .rd1(rd1), .rd2(rd2), .imm(imm), .reg_write(reg_write), .mem_write(mem_write),
    .ext_op(ext_op), .alu_op(alu_op), .npc_op(npc_op), .alu_src(alu_src),
    .dm_type(dm_type), .wd_sel(wd_sel), .alu_b(alu_b), .alu_c(alu_c), .zero(zero),
    .illegal(illegal), .c_q(c_q), .zero_q(zero_q), .illegal_seen(illegal_seen)
  );

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [5:0]  ext;
    logic [4:0]  aop;
    logic [2:0]  npc;
    logic        src;
    logic [2:0]  dm;
    logic [1:0]  wd;
    logic [31:0] b;
    logic [31:0] c;
    logic        z;
    logic        ill;
  } exp_t;

  typedef enum {
    I_ILL, I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU, I_JAL, I_JALR, I_LUI, I_AUIPC
  } mn_t;

  function automatic mn_t classify(input logic [6:0] o, input logic [6:0] f7, input logic [2:0] f3);
    mn_t m;
    bit  z7, a7;
    m  = I_ILL;
    z7 = (f7 == 7'h00);
    a7 = (f7 == 7'h20);
    case (o)
      7'h33: case (f3)
        3'd0: m = z7 ? I_ADD : (a7 ? I_SUB : I_ILL);
        3'd1: m = z7 ? I_SLL : I_ILL;
        3'd2: m = z7 ? I_SLT : I_ILL;
        3'd3: m = z7 ? I_SLTU : I_ILL;
        3'd4: m = z7 ? I_XOR : I_ILL;
        3'd5: m = z7 ? I_SRL : (a7 ? I_SRA : I_ILL);
        3'd6: m = z7 ? I_OR : I_ILL;
        default: m = z7 ? I_AND : I_ILL;
      endcase
      7'h13: case (f3)
        3'd0: m = I_ADDI;
        3'd1: m = z7 ? I_SLLI : I_ILL;
        3'd2: m = I_SLTI;
        3'd3: m = I_SLTIU;
        3'd4: m = I_XORI;
        3'd5: m = z7 ? I_SRLI : (a7 ? I_SRAI : I_ILL);
        3'd6: m = I_ORI;
        default: m = I_ANDI;
      endcase
      7'h03: case (f3)
        3'd0: m = I_LB;  3'd1: m = I_LH; 3'd2: m = I_LW;
        3'd4: m = I_LBU; 3'd5: m = I_LHU; default: m = I_ILL;
      endcase
      7'h23: case (f3)
        3'd0: m = I_SB; 3'd1: m = I_SH; 3'd2: m = I_SW; default: m = I_ILL;
      endcase
      7'h63: case (f3)
        3'd0: m = I_BEQ; 3'd1: m = I_BNE; 3'd4: m = I_BLT;
        3'd5: m = I_BGE; 3'd6: m = I_BLTU; 3'd7: m = I_BGEU; default: m = I_ILL;
      endcase
      7'h6f: m = I_JAL;
      7'h67: m = (f3 == 3'd0) ? I_JALR : I_ILL;
      7'h37: m = I_LUI;
      7'h17: m = I_AUIPC;
      default: m = I_ILL;
    endcase
    if (!SHIFT_EN && (m inside {I_SLL, I_SRL, I_SRA, I_SLLI, I_SRLI, I_SRAI})) m = I_ILL;
    return m;
  endfunction

  function automatic exp_t model(input logic [6:0] o, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im);
    exp_t        e;
    mn_t         m;
    logic [31:0] a, b, c;
    bit          taken;
    e = '0;
    c = 32'd0;
    taken = 1'b0;
    m = classify(o, f7, f3);
    e.ill = (m == I_ILL);
    case (m)
      I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND: e.rw = 1'b1;
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI: begin e.rw = 1; e.src = 1; e.ext = 6'b010000; end
      I_SLLI, I_SRLI, I_SRAI: begin e.rw = 1; e.src = 1; e.ext = 6'b100000; end
      I_LB, I_LH, I_LW, I_LBU, I_LHU: begin e.rw = 1; e.src = 1; e.ext = 6'b010000; e.wd = 2'b01; end
      I_SB, I_SH, I_SW: begin e.mw = 1; e.src = 1; e.ext = 6'b001000; end
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: e.ext = 6'b000100;
      I_JAL:  begin e.rw = 1; e.wd = 2'b10; e.ext = 6'b000001; e.npc = 3'b010; end
      I_JALR: begin e.rw = 1; e.wd = 2'b10; e.src = 1; e.ext = 6'b010000; e.npc = 3'b100; end
      I_LUI, I_AUIPC: begin e.rw = 1; e.src = 1; e.ext = 6'b000010; end
      default: ;
    endcase
    case (m)
      I_LB, I_SB: e.dm = 3'd3;
      I_LH, I_SH: e.dm = 3'd1;
      I_LBU:      e.dm = 3'd4;
      I_LHU:      e.dm = 3'd2;
      default:    e.dm = 3'd0;
    endcase
    case (m)
      I_LUI: e.aop = 5'd1;
      I_AUIPC: e.aop = 5'd2;
      I_ADD, I_ADDI, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW, I_JALR: e.aop = 5'd3;
      I_SUB, I_BEQ: e.aop = 5'd4;
      I_BNE: e.aop = 5'd5;   I_BLT: e.aop = 5'd6;   I_BGE: e.aop = 5'd7;
      I_BLTU: e.aop = 5'd8;  I_BGEU: e.aop = 5'd9;
      I_SLT, I_SLTI: e.aop = 5'd10;   I_SLTU, I_SLTIU: e.aop = 5'd11;
      I_XOR, I_XORI: e.aop = 5'd12;   I_OR, I_ORI: e.aop = 5'd13;   I_AND, I_ANDI: e.aop = 5'd14;
      I_SLL, I_SLLI: e.aop = 5'd15;   I_SRL, I_SRLI: e.aop = 5'd16; I_SRA, I_SRAI: e.aop = 5'd17;
      default: e.aop = 5'd0;
    endcase
    b = e.src ? im : r2;
    a = (m == I_AUIPC) ? p : r1;
    e.b = b;
    case (m)
      I_ADD, I_ADDI, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW, I_JALR, I_AUIPC: c = a + b;
      I_SUB: c = a - b;
      I_BEQ: begin taken = (a == b); c = a - b; end
      I_LUI: c = b;
      I_SLT, I_SLTI: c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      I_SLTU, I_SLTIU: c = (a < b) ? 32'd1 : 32'd0;
      I_XOR, I_XORI: c = a ^ b;
      I_OR, I_ORI: c = a | b;
      I_AND, I_ANDI: c = a & b;
      I_SLL, I_SLLI: c = a << b[4:0];
      I_SRL, I_SRLI: c = a >> b[4:0];
      I_SRA, I_SRAI: c = $signed(a) >>> b[4:0];
      I_BNE:  begin taken = (a != b); c = taken ? 32'd0 : 32'd1; end
      I_BLT:  begin taken = ($signed(a) < $signed(b)); c = taken ? 32'd0 : 32'd1; end
      I_BGE:  begin taken = ($signed(a) >= $signed(b)); c = taken ? 32'd0 : 32'd1; end
      I_BLTU: begin taken = (a < b); c = taken ? 32'd0 : 32'd1; end
      I_BGEU: begin taken = (a >= b); c = taken ? 32'd0 : 32'd1; end
      default: c = 32'd0;
    endcase
    e.c = c;
    e.z = (c == 32'd0);
    if (m inside {I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU}) e.npc = {2'b00, taken};
    return e;
  endfunction

  exp_t        cur, dut_v;
  logic [31:0] m_c;
  logic        m_z, m_ill;

  assign cur   = model(op, funct7, funct3, pc, rd1, rd2, imm);
  assign dut_v = {reg_write, mem_write, ext_op, alu_op, npc_op, alu_src, dm_type, wd_sel,
                  alu_b, alu_c, zero, illegal};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_c   <= 32'd0;
      m_z   <= 1'b0;
      m_ill <= 1'b0;
    end else begin
      m_c   <= cur.c;
      m_z   <= cur.z;
      m_ill <= m_ill | cur.ill;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (dut_v !== cur) begin
        errors++;
        $display("FAIL comb op=%h f7=%h f3=%h actual=%h required=%h", op, funct7, funct3, dut_v, cur);
      end
      checks++;
      if ({c_q, zero_q, illegal_seen} !== {m_c, m_z, m_ill}) begin
        errors++;
        $display("FAIL status actual=%h/%b/%b required=%h/%b/%b",
                 c_q, zero_q, illegal_seen, m_c, m_z, m_ill);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i);
    @(posedge clk);
    #1;
    op = o; funct7 = f7; funct3 = f3; pc = p; rd1 = a; rd2 = b; imm = i;
  endtask

  logic [6:0]  sw_op[7] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h03, 7'h23, 7'h63};
  logic [6:0]  sw_f7[7] = '{7'h00, 7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
  logic [6:0]  sp_op[7] = '{7'h6f, 7'h67, 7'h67, 7'h37, 7'h17, 7'h7f, 7'h33};
  logic [6:0]  sp_f7[7] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01};
  logic [2:0]  sp_f3[7] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [31:0] ds_pc[4] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0004, 32'h7FFF_FFFC};
  logic [31:0] ds_r1[4] = '{32'h0000_0005, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] ds_r2[4] = '{32'h0000_0007, 32'h0000_0003, 32'h0000_0001, 32'h7FFF_FFFF};
  logic [31:0] ds_im[4] = '{32'hFFFF_FFF0, 32'h0000_0003, 32'h0000_0404, 32'h0000_001F};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rstn = 1'b1;
    op = 7'h13; funct7 = 7'h00; funct3 = 3'd0; pc = 32'd0; rd1 = 32'd0; rd2 = 32'd0; imm = 32'd0;
    #2 rstn = 1'b0;
    cmp_en = 1'b1;
    #10;
    chk("rst_c_q", c_q, 32'd0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
    chk("rst_illegal_seen", {31'd0, illegal_seen}, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;

    drive(7'h33, 7'h20, 3'd0, 32'd0, 32'd5, 32'd7, 32'd0);
    #2;
    chk("sub_alu_op", {27'd0, alu_op}, 32'd4);
    chk("sub_alu_c", alu_c, 32'hFFFF_FFFE);
    chk("sub_zero", {31'd0, zero}, 32'd0);
    chk("sub_reg_write", {31'd0, reg_write}, 32'd1);
    chk("model_sub_c", cur.c, 32'hFFFF_FFFE);

    drive(7'h13, 7'h00, 3'd0, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF);
    #2;
    chk("addi_alu_src", {31'd0, alu_src}, 32'd1);
    chk("addi_ext_op", {26'd0, ext_op}, 32'b010000);
    chk("addi_alu_c", alu_c, 32'd0);
    chk("addi_zero", {31'd0, zero}, 32'd1);
    chk("c_q_after_sub", c_q, 32'hFFFF_FFFE);

    drive(7'h63, 7'h00, 3'd1, 32'd0, 32'd3, 32'd3, 32'd0);
    #2;
    chk("bne_eq_alu_c", alu_c, 32'd1);
    chk("bne_eq_npc", {29'd0, npc_op}, 32'd0);
    chk("zero_q_after_addi", {31'd0, zero_q}, 32'd1);
    chk("model_bne_eq_npc", {29'd0, cur.npc}, 32'd0);

    drive(7'h63, 7'h00, 3'd1, 32'd0, 32'd3, 32'd4, 32'd0);
    #2;
    chk("bne_ne_alu_c", alu_c, 32'd0);
    chk("bne_ne_npc", {29'd0, npc_op}, 32'd1);
    chk("model_bne_ne_npc", {29'd0, cur.npc}, 32'd1);

    drive(7'h23, 7'h00, 3'd2, 32'd0, 32'h100, 32'hDEAD_BEEF, 32'h8);
    #2;
    chk("sw_mem_write", {31'd0, mem_write}, 32'd1);
    chk("sw_reg_write", {31'd0, reg_write}, 32'd0);
    chk("sw_dm_type", {29'd0, dm_type}, 32'd0);
    chk("sw_ext_op", {26'd0, ext_op}, 32'b001000);
    chk("sw_alu_c", alu_c, 32'h108);
    chk("ill_seen_clear", {31'd0, illegal_seen}, 32'd0);

    drive(7'h7f, 7'h00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2;
    chk("ill_comb", {31'd0, illegal}, 32'd1);
    chk("ill_reg_write", {31'd0, reg_write}, 32'd0);
    drive(7'h13, 7'h00, 3'd0, 32'd0, 32'h55, 32'd0, 32'd0);
    #2;
    chk("ill_seen_set", {31'd0, illegal_seen}, 32'd1);
    drive(7'h13, 7'h00, 3'd0, 32'd0, 32'h55, 32'd0, 32'd0);
    #2;
    chk("ill_seen_sticky", {31'd0, illegal_seen}, 32'd1);
    chk("c_q_pre_reset", c_q, 32'h55);
    rstn = 1'b0;
    #1;
    chk("mid_rst_illegal_seen", {31'd0, illegal_seen}, 32'd0);
    chk("mid_rst_c_q", c_q, 32'd0);
    chk("mid_rst_alu_c", alu_c, 32'h55);
    @(negedge clk);
    #1 rstn = 1'b1;

    drive(7'h13, 7'h20, 3'd5, 32'd0, 32'h8000_0000, 32'd0, 32'h404);
    #2;
`ifdef EXU_SHIFT_EN
    chk("srai_alu_c", alu_c, 32'hF800_0000);
    chk("srai_reg_write", {31'd0, reg_write}, 32'd1);
`else
    chk("srai_illegal", {31'd0, illegal}, 32'd1);
    chk("srai_reg_write", {31'd0, reg_write}, 32'd0);
`endif

    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 7; k++)
        for (int f = 0; f < 8; f++)
          drive(sw_op[k], sw_f7[k], 3'(f), ds_pc[d], ds_r1[d], ds_r2[d], ds_im[d]);
      for (int k = 0; k < 7; k++)
        drive(sp_op[k], sp_f7[k], sp_f3[k], ds_pc[d], ds_r1[d], ds_r2[d], ds_im[d]);
    end

    @(negedge clk);
    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
